square_motion_ctrl: RTL
=======================

# square_motion_ctrl

Upstream control stage for the square renderer in the VGA path. It synchronizes and debounces the four push-button inputs (left, right, up, down). Once per video frame it advances the square's top-left position and holds that position constant for the whole frame, so the renderer never sees it change mid-scan. Outputs are registered in the iVGA_CLK domain and feed the renderer's position inputs directly.

## Interface
Parameters:
- DEB_CYCLES, 250000: number of consecutive stable samples before a button's debounced state changes.
- STEP, 4: pixels moved per frame per axis while a button is held.
- SQ_SIZE, 32: square edge length in pixels.
- X_MAX, 480: width of the play area (columns 0..X_MAX-1).
- Y_MAX, 480: height of the play area (rows 0..Y_MAX-1).
- X_INIT, 224: reset x position.
- Y_INIT, 224: reset y position.

Ports:
- iVGA_CLK, input, 1: pixel clock; the only clock.
- iRST_n, input, 1: synchronous, active-low reset.
- iVS, input, 1: vertical sync from the sync generator, active-low, already synchronous to iVGA_CLK.
- left, input, 1: raw button, 1 = pressed, asynchronous.
- right, input, 1: raw button, 1 = pressed, asynchronous.
- up, input, 1: raw button, 1 = pressed, asynchronous.
- down, input, 1: raw button, 1 = pressed, asynchronous.
- oX, output, 10: square top-left column.
- oY, output, 9: square top-left row.
- oMoved, output, 1: one-cycle pulse in the cycle oX/oY change.
- oBtn, output, 4: debounced button state {left, right, up, down}.

## Operation
- Synchronizer: each raw button passes through a 2-flop synchronizer.
- Debounce: one counter per button, width clog2(DEB_CYCLES+1).
  - While the synchronized value differs from oBtn[i], the counter increments.
  - Whenever the values match, the counter clears to 0.
  - When the counter reaches DEB_CYCLES-1 while still differing, oBtn[i] takes the new value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes oBtn.
- Frame tick: register iVS into vs_d. tick = vs_d & ~iVS, i.e. the falling edge of VS.
- Update FSM, states IDLE → CALC → COMMIT → IDLE:
  - IDLE: waits for tick.
  - CALC: samples oBtn into a latch and computes nx/ny in 11-bit unsigned arithmetic.
  - COMMIT: writes oX/oY and asserts oMoved if either value changed.
- Horizontal rule: left&~right moves x by -STEP; right&~left moves x by +STEP; both or neither leaves x unchanged.
- Vertical rule: same as horizontal, using up (-STEP) and down (+STEP).
- Clamp:
  - Decrement: if x < STEP then 0, else x-STEP.
  - Increment: if x+STEP > X_MAX-SQ_SIZE then X_MAX-SQ_SIZE, else x+STEP.
  - y uses the same rules with Y_MAX.
- A tick arriving while the FSM is in CALC or COMMIT is ignored. A frame is ≫3 cycles, so this does not occur in normal operation.

## Timing
- Reset values: oX=X_INIT, oY=Y_INIT, oMoved=0, oBtn=0, FSM=IDLE, counters=0, synchronizers=0, vs_d=1.
- Button latency, raw edge → oBtn change: 2 synchronizer cycles + DEB_CYCLES cycles.
- Frame latency: tick is in cycle T; CALC runs at T+1; oX/oY/oMoved update at the clock edge ending T+2 and are visible in T+3.
- Hold: oX/oY are constant between commits, at most one change per frame.
- oMoved: high for exactly 1 cycle. It stays 0 when the position is already clamped at a boundary.
- Reset mid-operation: iRST_n low at any clock edge restores all reset values on that edge. An in-flight CALC or COMMIT is discarded.
- The square is always fully inside the play area: 0 ≤ oX ≤ X_MAX-SQ_SIZE and 0 ≤ oY ≤ Y_MAX-SQ_SIZE.

## Test plan
Bench parameters: DEB_CYCLES=4, STEP=4, SQ_SIZE=32, X_MAX=Y_MAX=480, X_INIT=Y_INIT=224.
1. Reset: hold iRST_n=0 for 3 cycles, then release → oX=224, oY=224, oBtn=0, oMoved=0. Toggle iVS with no buttons pressed → oMoved never asserts.
2. Debounce: pulse right for 3 cycles → oBtn stays 0. Hold right for 10 cycles → oBtn[2] rises exactly 6 cycles after the raw edge.
3. Movement: hold right and down (debounced) across 5 VS falling edges → oX=244, oY=244. Each oMoved pulse occurs 3 cycles after its iVS fall.
4. Clamp: hold right across 100 frames → oX saturates at 448 and stays there; oMoved stops once oX=448. Hold left from oX=2, reached by preloading via parameter X_INIT=2 → oX=0 after one frame.
5. Conflict: left and right both held → oX unchanged over 3 frames. Same check for up and down with oY.
6. Mid-update reset: assert iRST_n=0 in the cycle after tick, with right held → oX=224 and oMoved=0 on the following cycle, with no stale commit afterward.

Source files
------------

// File: rtl/square_motion_ctrl.sv
// Button conditioning and once-per-frame position update for the VGA square renderer.
// Every output is registered in the iVGA_CLK domain and is held constant between frame commits.
module square_motion_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int STEP       = 4,
    parameter int SQ_SIZE    = 32,
    parameter int X_MAX      = 480,
    parameter int Y_MAX      = 480,
    parameter int X_INIT     = 224,
    parameter int Y_INIT     = 224
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic       oMoved,
    output logic [3:0] oBtn
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [10:0]       STEP_W   = 11'(STEP);
    localparam logic [10:0]       X_LIM    = 11'(X_MAX - SQ_SIZE);
    localparam logic [10:0]       Y_LIM    = 11'(Y_MAX - SQ_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        COMMIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        raw;
    logic [3:0]        sync1;
    logic [3:0]        sync2;
    logic [CNT_W-1:0]  deb_cnt [4];
    logic              vs_d;
    logic              tick;
    logic [10:0]       nx_calc;
    logic [10:0]       ny_calc;
    logic [10:0]       nx_q;
    logic [10:0]       ny_q;

    assign raw = {left, right, up, down};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // NOTE: the counter array is only four entries and must start from zero, so it is reset in a loop.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oBtn <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == oBtn[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    oBtn[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Frame tick is the falling edge of the active-low vertical sync.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            vs_d <= 1'b1;
        end else begin
            vs_d <= iVS;
        end
    end

    assign tick = vs_d & ~iVS;

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = CALC;
            CALC:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    function automatic logic [10:0] clamp_step(input logic [10:0] p, input logic dec,
                                               input logic inc, input logic [10:0] lim);
        if (dec && !inc) begin
            return (p < STEP_W) ? 11'd0 : p - STEP_W;
        end
        if (inc && !dec) begin
            return (p + STEP_W > lim) ? lim : p + STEP_W;
        end
        return p;
    endfunction

    assign nx_calc = clamp_step({1'b0, oX}, oBtn[3], oBtn[2], X_LIM);
    assign ny_calc = clamp_step({2'b0, oY}, oBtn[1], oBtn[0], Y_LIM);

    // CALC freezes the debounced buttons into the next position; COMMIT publishes it.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            nx_q   <= 11'(X_INIT);
            ny_q   <= 11'(Y_INIT);
            oX     <= 10'(X_INIT);
            oY     <= 9'(Y_INIT);
            oMoved <= 1'b0;
        end else begin
            oMoved <= 1'b0;
            if (state == CALC) begin
                nx_q <= nx_calc;
                ny_q <= ny_calc;
            end
            if (state == COMMIT) begin
                oX     <= nx_q[9:0];
                oY     <= ny_q[8:0];
                oMoved <= (nx_q[9:0] != oX) || (ny_q[8:0] != oY);
            end
        end
    end

endmodule
